serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder, the datapath stage built directly on top of the team's `half_adder` cell. Two half adders plus an OR form a full adder that is applied once per clock to one bit pair, LSB first. A carry flip-flop links the bits. Operands are captured on a start handshake, and the result is presented with a one-cycle done pulse. The block is a low-area alternative to a ripple adder for control-path arithmetic.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal range 2..32.
- `clk` in 1, single clock; all state updates on the rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `start` in 1, request to add; sampled only in IDLE or DONE.
- `a` in WIDTH, operand A; captured on the accepted `start`.
- `b` in WIDTH, operand B; captured on the accepted `start`.
- `cin` in 1, carry-in; captured with the operands. Present only with `SERIAL_ADDER_CIN_EN`.
- `busy` out 1, high while in RUN.
- `done` out 1, single-cycle pulse, high while in DONE.
- `sum` out WIDTH, registered result.
- `carry` out 1, registered carry-out of the MSB.

## Operation
- States:
  - IDLE: reset state.
  - RUN: adding, one bit per cycle.
  - DONE: result pulse, lasts one cycle.
- IDLE→RUN on `start`=1. The same edge loads:
  - operand shift registers sa←a and sb←b;
  - carry flop ← cin, or 0 when the macro is absent;
  - bit counter ← 0.
- RUN, each edge:
  - full adder computes s and c from sa[0], sb[0] and the carry flop;
  - s shifts into the MSB of the result shift register;
  - sa and sb shift right by 1;
  - carry flop ← c;
  - counter increments.
- RUN→DONE on the edge where counter == WIDTH-1, i.e. the WIDTH-th bit is processed. The same edge loads the `sum` output from the completed shift register and `carry` from the final c.
- DONE→IDLE when `start`=0. DONE→RUN when `start`=1, which allows back-to-back operations; the load occurs as for IDLE→RUN.
- `start` during RUN is ignored. The operands are not re-captured and no request is queued.
- `a`, `b` and `cin` may change freely after the accepting edge.
- `sum` and `carry` hold their value until the next DONE entry. They are not cleared on start.
- Arithmetic: {carry, sum} = a + b (+ cin), modulo 2^(WIDTH+1). No overflow flag.
- Reset values (asynchronous, while `rst_n`=0):
  - state IDLE;
  - `busy`=0, `done`=0;
  - `sum`=0, `carry`=0;
  - all shift registers, the carry flop and the counter cleared.
- Reset mid-RUN aborts the operation. No `done` is produced and the outputs read 0.

## Timing
- Accepting edge E0. `busy` is high from E0 through edge E(WIDTH).
- `done`=1, with `sum` and `carry` valid, in the cycle after edge E(WIDTH). Latency from start to done is WIDTH+1 edges.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- `done` and `busy` are never high together.
- `rst_n` release is treated synchronously by downstream logic. The first `start` is honoured on the first rising edge with `rst_n`=1.

## Configuration
- `SERIAL_ADDER_CIN_EN` defined: the `cin` port exists and is captured on the accepted start.
- `SERIAL_ADDER_CIN_EN` undefined: no `cin` port; the carry flop loads 0 on start.

## Structure
- Package `serial_adder_pkg` holds:
  - the state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a counter-width constant computed as clog2 of WIDTH.
- Sub-module `full_adder` (ports a, b, cin, sum, carry):
  - built from two `half_adder` instances and one OR gate;
  - instantiated once, combinational;
  - the only arithmetic in the block.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=8, a=8'h00, b=8'h00, start for one cycle -> `done` 9 edges after acceptance, sum=8'h00, carry=0, `busy` high for 8 cycles.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry=1; outputs hold after `done` falls.
- a=8'hA5, b=8'h5A, then `start` re-pulsed with a=8'h01 at the 4th RUN cycle -> result sum=8'hFF, carry=0; the second start is ignored.
- Back-to-back: start held high across DONE with a=8'h10, b=8'h20 then a=8'h7F, b=8'h01 -> results sum=8'h30 then sum=8'h80, each carry=0, no idle gap.
- `rst_n` pulsed low at the 4th RUN cycle of 8'hFF+8'hFF -> `busy`, `done`, `sum` and `carry` all 0 immediately; no `done` afterwards; the next start with 8'h03+8'h04 yields sum=8'h07.
- With `SERIAL_ADDER_CIN_EN`: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, carry=1. Without the macro the same operands give sum=8'hFF, carry=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared state encoding and sizing helpers for the bit-serial
//                adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    // State encoding for the serial adder controller
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Bit-counter width: clog2 of the operand width, never below one bit
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
//  Module      : full_adder
//  Description : One-bit full adder built from two half adders and an OR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // First stage adds the operand bits
    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (w_s1),
        .carry (w_c1)
    );

    // Second stage folds in the incoming carry
    half_adder u_ha1 (
        .a     (w_s1),
        .b     (cin),
        .sum   (sum),
        .carry (w_c2)
    );

    // The two partial carries can never both be set, so OR merges them
    assign carry = w_c1 | w_c2;

endmodule : full_adder

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
//  Module      : half_adder
//  Description : One-bit half adder cell (sum = a ^ b, carry = a & b).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule : half_adder

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder. Operands are captured on an
//                accepted start, summed LSB first one bit per clock through a
//                single full adder, and the result is presented with a
//                one-cycle done pulse.
//                Optional macro SERIAL_ADDER_CIN_EN adds a carry-in port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic             cf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;
    logic             load;
    logic             last;
    logic             cin_init;

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_init = cin;
`else
    assign cin_init = 1'b0;
`endif

    // A start is only honoured outside RUN; requests during RUN are dropped
    assign load = start && (state_q != S_RUN);
    assign last = (state_q == S_RUN) && (cnt_q == CNT_LAST);

    // The single full adder is the only arithmetic in the block
    full_adder u_fa (
        .a     (sa_q[0]),
        .b     (sb_q[0]),
        .cin   (cf_q),
        .sum   (fa_s),
        .carry (fa_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE/DONE accept start, RUN ends after WIDTH bits
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, bit-serial shifting and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            res_q  <= '0;
            cf_q   <= 1'b0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            sa_q  <= a;
            sb_q  <= b;
            cf_q  <= cin_init;
            cnt_q <= '0;
        end else if (state_q == S_RUN) begin
            sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
            sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
            res_q <= {fa_s, res_q[WIDTH-1:1]};
            cf_q  <= fa_c;
            cnt_q <= cnt_q + 1'b1;
            // On the final bit the result is taken straight from the shifter
            // input so it is valid in the DONE cycle
            if (last) begin
                sum_q  <= {fa_s, res_q[WIDTH-1:1]};
                cout_q <= fa_c;
            end
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign carry = cout_q;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8) with a
//                transaction-level reference model and directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;
`ifdef SERIAL_ADDER_CIN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int n_vec;
    int n_err;
    bit chk_en;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_CIN_EN
        .cin   (cin),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transaction is a number of busy cycles followed
    // by a done cycle carrying a + b (+ cin).
    // ------------------------------------------------------------------
    int           m_left;
    bit           m_done;
    logic [W:0]   m_pend;
    logic [W-1:0] m_sum;
    logic         m_carry;

    task automatic model_reset();
        m_left  = 0;
        m_done  = 1'b0;
        m_pend  = '0;
        m_sum   = '0;
        m_carry = 1'b0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    {m_carry, m_sum} = m_pend;
                end
            end else begin
                m_done = 1'b0;
                if (start) begin
                    m_pend = {1'b0, a} + {1'b0, b} + (W+1)'(CIN_EN ? cin : 1'b0);
                    m_left = W;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",  64'(busy),  64'(m_left > 0));
            chk("done",  64'(done),  64'(m_done));
            chk("sum",   64'(sum),   64'(m_sum));
            chk("carry", 64'(carry), 64'(m_carry));
        end
    end

    // Wait for done (bounded); returns latency counting the accepting edge
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nbusy++;
            @(posedge clk);
        end
        if (lat == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no done within 30 cycles at %0t", $time);
        end
    endtask

    // Single start pulse and literal check of the result
    task automatic do_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic [W-1:0] es, input logic ec,
                         output int lat, output int nbusy);
        @(posedge clk); #2;
        start = 1'b1; a = ia; b = ib; cin = ic;
        @(posedge clk); #2;
        start = 1'b0; a = $urandom; b = $urandom; cin = 1'b0;
        wait_done(lat, nbusy);
        chk({nm, "_sum"},   64'(sum),   64'(es));
        chk({nm, "_carry"}, 64'(carry), 64'(ec));
    endtask

    initial begin
        int lat;
        int nb;
        n_vec  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        model_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_sum",   64'(sum),   64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // 0 + 0: latency and busy length
        do_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, lat, nb);
        chk("zero_latency", 64'(lat), 64'd9);
        chk("zero_busy_cycles", 64'(nb), 64'd8);

        // FF + 01 wraps with carry, outputs hold afterwards
        do_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, lat, nb);
        repeat (3) @(negedge clk);
        chk("hold_sum",   64'(sum),   64'h00);
        chk("hold_carry", 64'(carry), 64'd1);
        chk("hold_done",  64'(done),  64'd0);

        // Start re-pulsed mid-RUN is ignored
        @(posedge clk); #2;
        start = 1'b1; a = 8'hA5; b = 8'h5A;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 start = 1'b1; a = 8'h01;
        @(posedge clk); #2 start = 1'b0;
        wait_done(lat, nb);
        chk("ign_sum",   64'(sum),   64'hFF);
        chk("ign_carry", 64'(carry), 64'd0);
        repeat (3) @(negedge clk);
        chk("ign_no_requeue", 64'(busy), 64'd0);

        // Back-to-back with start held across DONE
        @(posedge clk); #2;
        start = 1'b1; a = 8'h10; b = 8'h20;
        @(posedge clk); #2;
        a = 8'h7F; b = 8'h01;
        wait_done(lat, nb);
        chk("b2b1_sum",   64'(sum),   64'h30);
        chk("b2b1_carry", 64'(carry), 64'd0);
        @(posedge clk); #2 start = 1'b0;
        chk("b2b_no_gap", 64'(busy), 64'd1);
        wait_done(lat, nb);
        chk("b2b2_sum",   64'(sum),   64'h80);
        chk("b2b2_carry", 64'(carry), 64'd0);
        chk("b2b2_latency", 64'(lat), 64'd9);

        // Reset in the middle of RUN aborts
        @(posedge clk); #2;
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",  64'(busy),  64'd0);
        chk("abort_done",  64'(done),  64'd0);
        chk("abort_sum",   64'(sum),   64'd0);
        chk("abort_carry", 64'(carry), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nb++;
        end
        chk("abort_no_done", 64'(nb), 64'd0);
        do_op("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, lat, nb);

        // Carry-in case
        if (CIN_EN) do_op("cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, lat, nb);
        else        do_op("cin", 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0, lat, nb);

        // Randomized traffic, including starts during RUN and one async reset
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       a = 8'hFF;
                1:       a = 8'h00;
                default: a = W'($urandom);
            endcase
            b   = ($urandom_range(0, 4) == 0) ? 8'hFF : W'($urandom);
            cin = 1'($urandom_range(0, 1));
            if (i == 400) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(posedge clk); #2 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_adder

`default_nettype wire
